prep_divisor: RTL and testbench
===============================

PREP_DIVISOR -- requirements
Module: prep_divisor

Interface
REQ-001 Parameter tamanyo, default 32, operand and quotient width in bits.
REQ-002 Parameter ETAPAS, default 32, number of downstream subtract/compare stages this block feeds; range 1..64.
REQ-003 CLK  in  1  single clock; all state updates on rising edge.
REQ-004 RSTa  in  1  asynchronous, active-low reset.
REQ-005 Start  in  1  operand-valid strobe; one new division accepted per asserted cycle.
REQ-006 Num  in  tamanyo  signed two's-complement dividend.
REQ-007 Den  in  tamanyo  signed two's-complement divisor.
REQ-008 Q  out  tamanyo  initial partial quotient for the first stage.
REQ-009 Num_c2s  out  tamanyo  initial partial remainder, equal to |Num| as unsigned.
REQ-010 Den_abs  out  tamanyo  |Den| as unsigned.
REQ-011 Den_c2s  out  tamanyo  two's complement of Den_abs, i.e. -|Den| mod 2^tamanyo.
REQ-012 Start_out  out  1  registered Start; drives the first stage's Start.
REQ-013 Tag_valid  out  1  asserted when the sideband tag of an operation is presented, aligned with the last stage's Done.
REQ-014 Sign_Q  out  1  tag: quotient must be negated.
REQ-015 Sign_R  out  1  tag: remainder must be negated.
REQ-016 Div0  out  1  tag: divisor was zero; result is invalid.
REQ-017 En_vuelo  out  $clog2(ETAPAS+2)  count of accepted operations whose tag has not yet been presented.
REQ-018 Busy  out  1  high when En_vuelo is nonzero.

Function
REQ-019 Operand registers SHALL load on a rising edge with Start=1 and SHALL hold their previous values when Start=0.
REQ-020 Start_out SHALL equal Start delayed by exactly one cycle, regardless of Start value.
REQ-021 Q SHALL load all-zeros on every accepted operation.
REQ-022 Num_c2s SHALL load Num when Num[msb]=0, and (~Num + 1) truncated to tamanyo bits when Num[msb]=1.
REQ-023 Den_abs SHALL load by the same rule applied to Den; Den_c2s SHALL load (~Den_abs_next + 1) truncated to tamanyo bits.
REQ-024 The most negative input (-2^(tamanyo-1)) SHALL yield magnitude 2^(tamanyo-1) read as unsigned; no saturation and no error flag.
REQ-025 Sign_Q SHALL be Num[msb] XOR Den[msb]; Sign_R SHALL be Num[msb]; Div0 SHALL be 1 iff Den==0.
REQ-026 Den==0 SHALL produce Den_abs=0 and Den_c2s=0; the operation SHALL still be issued (Start_out=1).
REQ-027 Tags SHALL pass through a shift line of ETAPAS entries (valid, Sign_Q, Sign_R, Div0) and appear on Tag_valid/Sign_Q/Sign_R/Div0 exactly ETAPAS+1 cycles after the accepting edge.
REQ-028 When no valid tag is at the head of the line, Tag_valid SHALL be 0 and Sign_Q, Sign_R, Div0 SHALL be 0.
REQ-029 Back-to-back Start on consecutive cycles SHALL be accepted every cycle; tags SHALL emerge in acceptance order with no gaps or merging.
REQ-030 En_vuelo SHALL increment on an accepting edge, decrement on an edge where Tag_valid=1, and stay unchanged when both occur together.
REQ-031 En_vuelo SHALL never exceed ETAPAS+1 and SHALL never underflow.
REQ-032 There SHALL be no backpressure; Start is always accepted.

Reset
REQ-033 RSTa=0 SHALL immediately clear all outputs, operand registers, the tag line and En_vuelo to 0, independent of CLK.
REQ-034 Reset mid-operation SHALL discard all in-flight tags; no Tag_valid SHALL appear for operations accepted before the reset.
REQ-035 The first rising edge after RSTa returns high SHALL behave as normal operation.

Verification (tamanyo=8, ETAPAS=4)
REQ-036 Num=-7 (0xF9), Den=2, Start one cycle -> next cycle: Num_c2s=7, Den_abs=2, Den_c2s=0xFE, Q=0, Start_out=1; 5 cycles after acceptance: Tag_valid=1, Sign_Q=1, Sign_R=1, Div0=0.
REQ-037 Num=-128 (0x80), Den=-1 (0xFF) -> Num_c2s=0x80, Den_abs=1, Den_c2s=0xFF; Sign_Q=0, Sign_R=1.
REQ-038 Num=5, Den=0 -> Den_abs=0, Den_c2s=0, Start_out=1; tag after 5 cycles with Div0=1.
REQ-039 Start high for 6 consecutive cycles with distinct signs -> En_vuelo rises to 5 and holds at 5 while Start stays high; tags emerge in order on 6 consecutive cycles; En_vuelo returns to 0 and Busy falls 5 cycles after the last acceptance.
REQ-040 Assert RSTa=0 two cycles after three accepted operations -> all outputs 0 immediately; no Tag_valid afterwards; En_vuelo=0.
REQ-041 Start=0 after one operation -> operand outputs hold their last values and Start_out=0.

Source files
------------

// File: rtl/prep_divisor.sv
// Operand preparation stage for a pipelined signed divider.
// Produces magnitudes, negated divisor and a delayed sign/div0 tag.
module prep_divisor #(
    parameter int tamanyo = 32,
    parameter int ETAPAS  = 32
) (
    input  logic                          CLK,
    input  logic                          RSTa,
    input  logic                          Start,
    input  logic [tamanyo-1:0]            Num,
    input  logic [tamanyo-1:0]            Den,
    output logic [tamanyo-1:0]            Q,
    output logic [tamanyo-1:0]            Num_c2s,
    output logic [tamanyo-1:0]            Den_abs,
    output logic [tamanyo-1:0]            Den_c2s,
    output logic                          Start_out,
    output logic                          Tag_valid,
    output logic                          Sign_Q,
    output logic                          Sign_R,
    output logic                          Div0,
    output logic [$clog2(ETAPAS+2)-1:0]   En_vuelo,
    output logic                          Busy
);

    localparam int CW = $clog2(ETAPAS + 2);
    localparam logic [tamanyo-1:0] ONE = tamanyo'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef struct packed {
        logic v;
        logic sq;
        logic sr;
        logic d0;
    } tag_t;

    logic [tamanyo-1:0] num_mag;
    logic [tamanyo-1:0] den_mag;
    logic [tamanyo-1:0] den_neg;
    tag_t               tag_in;
    tag_t               head;
    tag_t               line [ETAPAS];

    // Magnitudes and tag of the operands currently on the inputs
    always_comb begin
        num_mag = Num[tamanyo-1] ? (~Num + ONE) : Num;
        den_mag = Den[tamanyo-1] ? (~Den + ONE) : Den;
        den_neg = ~den_mag + ONE;
        tag_in  = '0;
        if (Start) begin
            tag_in.v  = 1'b1;
            tag_in.sq = Num[tamanyo-1] ^ Den[tamanyo-1];
            tag_in.sr = Num[tamanyo-1];
            tag_in.d0 = (Den == '0);
        end
    end

    assign head = line[ETAPAS-1];

    // Operand registers load on an accepted operation, hold otherwise
    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa) begin
            Q       <= '0;
            Num_c2s <= '0;
            Den_abs <= '0;
            Den_c2s <= '0;
        end else if (Start) begin
            Q       <= '0;
            Num_c2s <= num_mag;
            Den_abs <= den_mag;
            Den_c2s <= den_neg;
        end
    end

    // First-stage start is the strobe delayed by one cycle
    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa) begin
            Start_out <= 1'b0;
        end else begin
            Start_out <= Start;
        end
    end

    // Tag shift line tracking the operation through the downstream stages
    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa) begin
            for (int i = 0; i < ETAPAS; i++) begin
                line[i] <= '0;
            end
        end else begin
            line[0] <= tag_in;
            for (int i = 1; i < ETAPAS; i++) begin
                line[i] <= line[i-1];
            end
        end
    end

    // Tag presentation register; fields forced low without a valid head
    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa) begin
            Tag_valid <= 1'b0;
            Sign_Q    <= 1'b0;
            Sign_R    <= 1'b0;
            Div0      <= 1'b0;
        end else begin
            Tag_valid <= head.v;
            Sign_Q    <= head.v & head.sq;
            Sign_R    <= head.v & head.sr;
            Div0      <= head.v & head.d0;
        end
    end

    // In-flight counter: accepted operations whose tag is not yet consumed
    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa) begin
            En_vuelo <= '0;
        end else begin
            unique case ({Start, Tag_valid})
                2'b10:   En_vuelo <= En_vuelo + CNT_ONE;
                2'b01:   En_vuelo <= En_vuelo - CNT_ONE;
                default: En_vuelo <= En_vuelo;
            endcase
        end
    end

    assign Busy = (En_vuelo != '0);

endmodule

// File: tb/tb_prep_divisor.sv
// Randomized self-checking bench for prep_divisor.
// Reference model keeps a per-edge log of accepted operations.
module tb_prep_divisor;

    localparam int W  = 8;
    localparam int ST = 4;
    localparam int CW = $clog2(ST + 2);
    localparam int NE = 1024;

    logic          CLK = 1'b0;
    logic          RSTa = 1'b0;
    logic          Start = 1'b0;
    logic [W-1:0]  Num = '0;
    logic [W-1:0]  Den = '0;
    logic [W-1:0]  Q;
    logic [W-1:0]  Num_c2s;
    logic [W-1:0]  Den_abs;
    logic [W-1:0]  Den_c2s;
    logic          Start_out;
    logic          Tag_valid;
    logic          Sign_Q;
    logic          Sign_R;
    logic          Div0;
    logic [CW-1:0] En_vuelo;
    logic          Busy;

    prep_divisor #(.tamanyo(W), .ETAPAS(ST)) dut (
        .CLK(CLK), .RSTa(RSTa), .Start(Start), .Num(Num), .Den(Den),
        .Q(Q), .Num_c2s(Num_c2s), .Den_abs(Den_abs), .Den_c2s(Den_c2s),
        .Start_out(Start_out), .Tag_valid(Tag_valid), .Sign_Q(Sign_Q),
        .Sign_R(Sign_R), .Div0(Div0), .En_vuelo(En_vuelo), .Busy(Busy)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;
    bit acc  [NE];
    bit a_sq [NE];
    bit a_sr [NE];
    bit a_d0 [NE];
    int e_num = 0;
    int e_dabs = 0;
    int e_dc2s = 0;
    int e_so = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h edge=%0d", tag, got, exp, edge_n);
        end
    endtask

    function automatic int mag(input logic [W-1:0] x);
        int s;
        s = int'($signed(x));
        return (s < 0) ? -s : s;
    endfunction

    // Tag of an op accepted at edge n is visible after edge n+ST and
    // consumed at edge n+ST+1, so it is counted over ST+1 edges.
    task automatic check_outs();
        int h;
        bit tv;
        int cnt;
        h = edge_n - ST;
        tv = (h >= 0) && acc[h];
        cnt = 0;
        for (int k = 0; k <= ST; k++) begin
            if (edge_n - k >= 0 && acc[edge_n-k]) cnt++;
        end
        chk("q", Q, 0);
        chk("num_c2s", Num_c2s, e_num);
        chk("den_abs", Den_abs, e_dabs);
        chk("den_c2s", Den_c2s, e_dc2s);
        chk("start_out", Start_out, e_so);
        chk("tag_valid", Tag_valid, tv);
        chk("sign_q", Sign_Q, tv && a_sq[h]);
        chk("sign_r", Sign_R, tv && a_sr[h]);
        chk("div0", Div0, tv && a_d0[h]);
        chk("en_vuelo", En_vuelo, cnt);
        chk("busy", Busy, cnt != 0);
    endtask

    task automatic cycle(input bit st, input logic [W-1:0] n,
                         input logic [W-1:0] d);
        Start = st;
        Num = n;
        Den = d;
        @(posedge CLK);
        edge_n++;
        if (st) begin
            acc[edge_n]  = 1'b1;
            a_sq[edge_n] = n[W-1] ^ d[W-1];
            a_sr[edge_n] = n[W-1];
            a_d0[edge_n] = (d == 0);
            e_num  = mag(n);
            e_dabs = mag(d);
            e_dc2s = ((1 << W) - e_dabs) % (1 << W);
        end
        e_so = st;
        @(negedge CLK);
        check_outs();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_q"}, Q, 0);
        chk({tag, "_num"}, Num_c2s, 0);
        chk({tag, "_dabs"}, Den_abs, 0);
        chk({tag, "_dc2s"}, Den_c2s, 0);
        chk({tag, "_so"}, Start_out, 0);
        chk({tag, "_tv"}, Tag_valid, 0);
        chk({tag, "_tags"}, {Sign_Q, Sign_R, Div0}, 0);
        chk({tag, "_cnt"}, En_vuelo, 0);
        chk({tag, "_busy"}, Busy, 0);
    endtask

    task automatic do_reset();
        #2 RSTa = 1'b0;
        Start = 1'b1;
        #1 check_zero("rst_async");
        for (int i = 0; i < NE; i++) acc[i] = 1'b0;
        e_num = 0;
        e_dabs = 0;
        e_dc2s = 0;
        e_so = 0;
        @(posedge CLK);
        edge_n++;
        @(negedge CLK);
        check_zero("rst_edge");
        RSTa = 1'b1;
    endtask

    function automatic logic [W-1:0] rnd_val();
        int r;
        r = $urandom_range(0, 15);
        if (r == 0) return '0;
        if (r == 1) return 8'h80;
        if (r == 2) return 8'hFF;
        if (r == 3) return 8'h7F;
        return W'($urandom);
    endfunction

    initial begin
        #1 check_zero("por");
        @(negedge CLK);
        RSTa = 1'b1;

        cycle(1'b1, 8'hF9, 8'h02);
        chk("d36_num", Num_c2s, 32'h07);
        chk("d36_dabs", Den_abs, 32'h02);
        chk("d36_dc2s", Den_c2s, 32'hFE);
        chk("d36_so", Start_out, 1);
        for (int i = 0; i < ST; i++) cycle(1'b0, 8'h00, 8'h00);
        chk("d36_tv", {Tag_valid, Sign_Q, Sign_R, Div0}, 4'b1110);
        chk("d41_hold", Num_c2s, 32'h07);
        cycle(1'b0, 8'h00, 8'h00);

        cycle(1'b1, 8'h80, 8'hFF);
        chk("d37_num", Num_c2s, 32'h80);
        chk("d37_dabs", Den_abs, 32'h01);
        chk("d37_dc2s", Den_c2s, 32'hFF);
        for (int i = 0; i < ST + 1; i++) cycle(1'b0, 8'h00, 8'h00);

        cycle(1'b1, 8'h05, 8'h00);
        chk("d38_dabs", {Den_abs, Den_c2s}, 0);
        for (int i = 0; i < ST; i++) cycle(1'b0, 8'h00, 8'h00);
        chk("d38_div0", {Tag_valid, Div0}, 2'b11);
        cycle(1'b0, 8'h00, 8'h00);

        cycle(1'b1, 8'h03, 8'h02);
        cycle(1'b1, 8'hFD, 8'h02);
        cycle(1'b1, 8'h03, 8'hFE);
        cycle(1'b1, 8'hFD, 8'hFE);
        cycle(1'b1, 8'h10, 8'h00);
        chk("d39_peak", En_vuelo, ST + 1);
        cycle(1'b1, 8'h80, 8'h80);
        chk("d39_hold", En_vuelo, ST + 1);
        for (int i = 0; i < ST + 2; i++) cycle(1'b0, 8'h00, 8'h00);
        chk("d39_idle", Busy, 0);

        cycle(1'b1, 8'h11, 8'h22);
        cycle(1'b1, 8'hF0, 8'h03);
        cycle(1'b1, 8'h40, 8'hC0);
        cycle(1'b0, 8'h00, 8'h00);
        cycle(1'b0, 8'h00, 8'h00);
        do_reset();
        for (int i = 0; i < ST + 2; i++) cycle(1'b0, 8'h00, 8'h00);

        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset();
            cycle(($urandom_range(0, 3) != 0), rnd_val(), rnd_val());
        end
        for (int i = 0; i < ST + 2; i++) cycle(1'b0, 8'h00, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
